ysyx_23060201_lsu: RTL and testbench
====================================

// Module: ysyx_23060201_lsu
// PURPOSE
//   Load/store initiator between EXU and the data memory port (mem_ren/mem_wen DPI memory).
//   Accepts one load/store per handshake, checks alignment, drives word-aligned memory
//   requests with byte-lane masks, then returns lane-shifted, sign/zero-extended load data
//   to WBU. One outstanding access; misaligned accesses never reach memory.
// PARAMETERS
//   ADDR_WIDTH  32  byte address width of core and memory port
//   DATA_WIDTH  32  data width; only 32 is supported (4 byte lanes)
// PORTS
//   clk         in   1   clock, all state updates on posedge
//   rst         in   1   synchronous reset, active-high
//   in_valid    in   1   EXU request valid
//   in_ready    out  1   LSU can accept (state==IDLE)
//   in_load     in   1   request is a load
//   in_store    in   1   request is a store
//   in_funct3   in   3   RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//   in_addr     in   32  byte address
//   in_wdata    in   32  store data, right-aligned
//   out_valid   out  1   response valid to WBU
//   out_ready   in   1   WBU accepts response
//   out_rdata   out  32  extended load data; 0 for stores and errors
//   out_err     out  1   access rejected (misaligned, illegal funct3, load&store both set)
//   mem_ren     out  1   memory read strobe; memory returns data on mem_rdata next cycle
//   mem_raddr   out  32  word-aligned read address (in_addr & ~3)
//   mem_rmask   out  8   read byte-lane mask, bits [3:0] used, [7:4]=0
//   mem_rdata   in   32  memory read data, registered by memory at posedge after mem_ren
//   mem_wen     out  1   memory write strobe; memory writes on negedge of same cycle
//   mem_waddr   out  32  word-aligned write address
//   mem_wmask   out  8   write byte-lane mask, bits [3:0] used, [7:4]=0
//   mem_wdata   out  32  store data shifted to lane position (wdata << 8*addr[1:0])
// BEHAVIOUR
//   States: IDLE, REQ, WAIT, RESP. Request fields latched on in_valid&in_ready.
//   IDLE: in_ready=1. Accept -> REQ if legal load/store; -> RESP with out_err=1 if illegal;
//     -> RESP with out_err=0, out_rdata=0 if neither in_load nor in_store (no memory access).
//   Alignment: H needs addr[0]=0, W needs addr[1:0]=0; B always aligned.
//   Masks: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
//   REQ (exactly 1 cycle): load -> mem_ren=1, go WAIT; store -> mem_wen=1, go RESP.
//   WAIT (1 cycle): capture mem_rdata >> 8*addr[1:0]; extend per funct3 (B/H sign, BU/HU zero,
//     W as-is) into out_rdata; go RESP.
//   RESP: out_valid=1, out_rdata/out_err held stable until out_ready; on out_valid&out_ready -> IDLE.
//     No same-cycle re-accept (in_ready=0 in RESP).
//   Latency from accept edge T: store out_valid at T+2, load T+3, error/no-op T+1.
//   mem_ren, mem_wen never both 1; each high for one cycle per access; 0 outside REQ.
//   mem_* addr/mask/wdata are 0 whenever their strobe is 0.
//   Reset: state=IDLE; in_ready=1 after reset; out_valid=0, out_rdata=0, out_err=0,
//     mem_ren=0, mem_wen=0, all mem address/mask/data outputs 0.
//   Reset mid-operation: next state IDLE, pending response dropped; a mem_wen already high in
//     the reset cycle completes in memory (negedge write), no response is produced for it.
//   out_ready ignored outside RESP; in_* ignored outside IDLE.
// TESTING
//   Reset, then in_store SW addr 0x80000004 wdata 0xDEADBEEF -> T+1 mem_wen=1, waddr 0x80000004,
//     wmask 0x0F, wdata 0xDEADBEEF; T+2 out_valid, out_err=0.
//   SB addr 0x80000003 wdata 0x000000A5 -> wmask 0x08, mem_wdata 0xA5000000.
//   Memory word 0x80000000=0x8001F07F; LB addr+3 -> 0xFFFFFF80; LBU addr+3 -> 0x00000080;
//     LH addr+2 -> 0xFFFF8001; LHU addr+0 -> 0x0000F07F; each out_valid at T+3, mem_rmask matches.
//   LW addr 0x80000002 -> out_valid at T+1, out_err=1, mem_ren/mem_wen never asserted.
//   Hold out_ready=0 for 5 cycles in RESP -> out_valid, out_rdata stable, in_ready=0, no new access.
//   Assert rst during WAIT of a load -> next cycle IDLE, out_valid=0, all mem outputs 0.

Source files
------------

// File: rtl/ysyx_23060201_lsu.sv
// rtl/ysyx_23060201_lsu.sv - load/store unit: alignment check, lane masks, load extension
// One outstanding access; IDLE -> REQ -> (WAIT) -> RESP, errors and no-ops go straight to RESP.
module ysyx_23060201_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_load,
  input  logic                  in_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]            mem_rmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state, state_n;
  logic                  ld_q, st_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  f3_ok, aligned, acc_err, accept;
  logic [3:0]            lane_mask;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] shifted, ext_data;

  assign accept    = in_valid && (state == IDLE);
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign shifted   = mem_rdata >> {addr_q[1:0], 3'b000};

  // Request legality, evaluated on the live inputs at the accept edge
  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b1;
    case (in_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = in_load;
      default:                f3_ok = 1'b0;
    endcase
    case (in_funct3[1:0])
      2'b01:   aligned = ~in_addr[0];
      2'b10:   aligned = (in_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    acc_err = (in_load & in_store) | ((in_load | in_store) & ~(f3_ok & aligned));
  end

  always_comb begin
    lane_mask = 4'b1111;
    ext_data  = shifted;
    case (f3_q[1:0])
      2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
      2'b01:   lane_mask = 4'b0011 << addr_q[1:0];
      default: lane_mask = 4'b1111;
    endcase
    case (f3_q)
      3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext_data = {24'h0, shifted[7:0]};
      3'b101:  ext_data = {16'h0, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        ld_q    <= in_load;
        st_q    <= in_store;
        f3_q    <= in_funct3;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        rdata_q <= '0;
        err_q   <= acc_err;
      end else if (state == WAIT) begin
        rdata_q <= ext_data;
      end
    end
  end

  // Memory-side outputs are forced to zero whenever their strobe is low
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_raddr = '0;
    mem_rmask = 8'h00;
    mem_waddr = '0;
    mem_wmask = 8'h00;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ((in_load | in_store) && !acc_err) ? REQ : RESP;
      end
      REQ: begin
        if (ld_q) begin
          mem_ren   = 1'b1;
          mem_raddr = word_addr;
          mem_rmask = {4'b0000, lane_mask};
          state_n   = WAIT;
        end else begin
          mem_wen   = st_q;
          mem_waddr = st_q ? word_addr : '0;
          mem_wmask = st_q ? {4'b0000, lane_mask} : 8'h00;
          mem_wdata = st_q ? (wdata_q << {addr_q[1:0], 3'b000}) : '0;
          state_n   = RESP;
        end
      end
      WAIT: state_n = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_rdata = rdata_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// tb/tb_ysyx_23060201_lsu.sv - randomized LSU bench against a byte-array reference model
module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [7:0]  mem_rmask, mem_wmask;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_bytes [64];
  logic [31:0] mem_words [16];

  always #5 clk = ~clk;

  ysyx_23060201_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata)
  );

  always @(posedge clk) if (mem_ren) mem_rdata <= mem_words[mem_raddr[5:2]];

  always @(negedge clk) begin
    if (mem_wen) begin
      for (int l = 0; l < 4; l++)
        if (mem_wmask[l]) mem_words[mem_waddr[5:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3, input logic [5:0] off,
                       input logic [31:0] wd, input int hold, output logic [31:0] got);
    int          nb, lat, ren_cnt, wen_cnt, elat, waited;
    bit          legal, mis, err, gate_bad;
    logic [31:0] ev, emask, ewd, a;
    logic [31:0] c_raddr, c_waddr, c_wdata;
    logic [7:0]  c_rmask, c_wmask;
    a     = 32'h8000_0000 | {26'h0, off};
    nb    = 1 << f3[1:0];
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    mis   = (int'(off) % nb) != 0;
    err   = (ld && st) || ((ld || st) && (!legal || mis));
    ev    = 32'h0;
    if (ld && !err) begin
      for (int i = 0; i < nb; i++) ev = ev | (32'(ref_bytes[int'(off) + i]) << (8 * i));
      if (!f3[2] && nb < 4 && ev[8*nb-1]) ev = ev | (32'hFFFF_FFFF << (8 * nb));
    end
    emask = ((32'd1 << nb) - 32'd1) << off[1:0];
    ewd   = wd << (8 * off[1:0]);
    elat  = (err || !(ld || st)) ? 1 : (st ? 2 : 3);

    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd;
    @(negedge clk);
    // inputs are don't-care once accepted; scramble them to catch re-latching
    in_valid = $urandom_range(0, 1); in_load = $urandom_range(0, 1); in_store = $urandom_range(0, 1);
    in_funct3 = $urandom_range(0, 7); in_addr = $urandom; in_wdata = $urandom;

    lat = 0; ren_cnt = 0; wen_cnt = 0; gate_bad = 0;
    c_raddr = 0; c_waddr = 0; c_wdata = 0; c_rmask = 0; c_wmask = 0;
    for (int n = 1; n <= 12; n++) begin
      if (mem_ren) begin ren_cnt++; c_raddr = mem_raddr; c_rmask = mem_rmask; end
      if (mem_wen) begin wen_cnt++; c_waddr = mem_waddr; c_wmask = mem_wmask; c_wdata = mem_wdata; end
      if ((mem_ren && mem_wen) ||
          (!mem_ren && (mem_raddr != 0 || mem_rmask != 0)) ||
          (!mem_wen && (mem_waddr != 0 || mem_wmask != 0 || mem_wdata != 0)))
        gate_bad = 1;
      if (out_valid) begin lat = n; break; end
      @(negedge clk);
    end
    got = out_rdata;
    check("latency", 32'(lat), 32'(elat));
    check("out_err", 32'(out_err), 32'(err));
    check("out_rdata", out_rdata, ev);
    check("ren_count", 32'(ren_cnt), (ld && !err) ? 32'd1 : 32'd0);
    check("wen_count", 32'(wen_cnt), (st && !err) ? 32'd1 : 32'd0);
    check("strobe_gating", 32'(gate_bad), 32'd0);
    if (ld && !err) begin
      check("raddr", c_raddr, a & ~32'd3);
      check("rmask", 32'(c_rmask), emask);
    end
    if (st && !err) begin
      check("waddr", c_waddr, a & ~32'd3);
      check("wmask", 32'(c_wmask), emask);
      check("wdata", c_wdata, ewd);
      for (int i = 0; i < nb; i++) ref_bytes[int'(off) + i] = wd[8*i +: 8];
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_flags", {28'h0, out_valid, in_ready, mem_ren, mem_wen}, 32'h8);
      check("hold_rdata", out_rdata, ev);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("back_to_idle", {30'h0, out_valid, in_ready}, 32'h1);
  endtask

  task automatic reset_dut(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] got;
  int          kind;
  logic [2:0]  rf3;
  logic [5:0]  roff;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_funct3 = 3'b0;
    in_addr = 32'h0; in_wdata = 32'h0; out_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_bytes[i] = 8'($urandom);
    for (int w = 0; w < 16; w++)
      mem_words[w] = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    @(negedge clk);
    reset_dut(3);
    check("rst_flags", {27'h0, in_ready, out_valid, out_err, mem_ren, mem_wen}, 32'h10);
    check("rst_rdata", out_rdata, 32'h0);
    check("rst_mem_out", mem_raddr | mem_waddr | mem_wdata | {24'h0, mem_rmask | mem_wmask}, 32'h0);

    do_op(1'b0, 1'b1, 3'b010, 6'h04, 32'hDEADBEEF, 0, got);
    do_op(1'b0, 1'b1, 3'b000, 6'h03, 32'h000000A5, 0, got);
    do_op(1'b0, 1'b1, 3'b010, 6'h00, 32'h8001F07F, 0, got);
    do_op(1'b1, 1'b0, 3'b000, 6'h03, 32'h0, 0, got);
    check("lb_const", got, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 3'b100, 6'h03, 32'h0, 0, got);
    check("lbu_const", got, 32'h00000080);
    do_op(1'b1, 1'b0, 3'b001, 6'h02, 32'h0, 0, got);
    check("lh_const", got, 32'hFFFF8001);
    do_op(1'b1, 1'b0, 3'b101, 6'h00, 32'h0, 5, got);
    check("lhu_const", got, 32'h0000F07F);
    do_op(1'b1, 1'b0, 3'b010, 6'h02, 32'h0, 0, got);
    do_op(1'b0, 1'b0, 3'b010, 6'h01, 32'h12345678, 2, got);
    do_op(1'b1, 1'b1, 3'b000, 6'h00, 32'h12345678, 0, got);
    do_op(1'b1, 1'b0, 3'b100, 6'h04, 32'h0, 0, got);
    check("lbu_after_sw", got, 32'h000000EF);

    // reset while a load sits in WAIT
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'b010;
    in_addr = 32'h8000_0008; in_wdata = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_req_ren", 32'(mem_ren), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait_flags", {27'h0, in_ready, out_valid, out_err, mem_ren, mem_wen}, 32'h10);
    check("rst_wait_mem", mem_raddr | mem_waddr | mem_wdata | {24'h0, mem_rmask | mem_wmask}, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_no_resp", {30'h0, out_valid, in_ready}, 32'h1);

    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 9);
      rf3  = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      if (kind < 4 && $urandom_range(0, 2) == 0) rf3 = 3'($urandom_range(4, 5));
      roff = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) roff = roff & ~((6'd1 << rf3[1:0]) - 6'd1);
      do_op(kind < 4 || kind == 9, (kind >= 4 && kind < 8) || kind == 9, rf3, roff, $urandom,
            $urandom_range(0, 2), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
